// File: rtl/cpu_pkg.sv
// Shared types for the MIPS pipeline: MEM-stage state
// and the EX/MEM and MEM/WB register bundles.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_t;

  typedef struct packed {
    logic                  valid;
    logic                  memread;
    logic                  memwrite;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] WA;
    logic [DATA_W-1:0]     alu_out;
    logic [DATA_W-1:0]     store_data;
  } ex_mem_t;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] WA;
    logic [DATA_W-1:0]     data;
  } mem_wb_t;

  function automatic logic is_mem_op(
    input logic valid,
    input logic rd,
    input logic wr
  );
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/dcache_req_fsm.sv
// Data-cache request sequencer: tracks the EX/MEM memory op
// through request and response and produces the pipeline stall.
module dcache_req_fsm (
  input  logic clk,
  input  logic rst,
  input  logic next_mem,
  input  logic mem_we,
  input  logic dc_req_ready,
  input  logic dc_resp_valid,
  output logic dc_req_valid,
  output logic dc_req_we,
  output logic mem_stall
);
  import cpu_pkg::*;

  mem_state_t state;
  logic in_req;
  logic in_wait;
  logic complete;

  always_comb begin
    in_req    = (state == REQ);
    in_wait   = (state == WAIT);
    complete  = (in_req & dc_req_ready & mem_we)
              | (in_wait & dc_resp_valid);
    mem_stall = (in_req | in_wait) & ~complete;
  end

  assign dc_req_valid = in_req;
  assign dc_req_we    = mem_we;

  // A new op enters REQ on the same edge it is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (!mem_stall) begin
      state <= next_mem ? REQ : IDLE;
    end else if (in_req && dc_req_ready) begin
      state <= WAIT;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// EX/MEM and MEM/WB pipeline registers around the
// data-cache access sequencer for the 5-stage MIPS core.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_regwrite,
  input  logic [4:0]        ex_WA,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic              dc_req_we,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic [DATA_W-1:0] dc_req_wdata,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_rdata,
  output logic              mem_stall,
  output logic              EX_MEM_memread,
  output logic              EX_MEM_regwrite,
  output logic [4:0]        EX_MEM_WA,
  output logic [DATA_W-1:0] EX_MEM_alu_out,
  output logic              MEM_WB_valid,
  output logic              MEM_WB_regwrite,
  output logic [4:0]        MEM_WB_WA,
  output logic [DATA_W-1:0] MEM_WB_data
);
  import cpu_pkg::*;

  ex_mem_t ex_mem;
  mem_wb_t mem_wb;
  logic    next_mem;

  assign next_mem = is_mem_op(ex_valid, ex_memread, ex_memwrite);

  dcache_req_fsm u_fsm (
    .clk           (clk),
    .rst           (rst),
    .next_mem      (next_mem),
    .mem_we        (ex_mem.memwrite),
    .dc_req_ready  (dc_req_ready),
    .dc_resp_valid (dc_resp_valid),
    .dc_req_valid  (dc_req_valid),
    .dc_req_we     (dc_req_we),
    .mem_stall     (mem_stall)
  );

  // While stalled, MEM/WB takes bubbles so the op retires once.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem <= '0;
      mem_wb <= '0;
    end else if (!mem_stall) begin
      ex_mem.valid      <= ex_valid;
      ex_mem.memread    <= ex_memread;
      ex_mem.memwrite   <= ex_memwrite;
      ex_mem.regwrite   <= ex_regwrite;
      ex_mem.WA         <= ex_WA;
      ex_mem.alu_out    <= ex_alu_out;
      ex_mem.store_data <= ex_store_data;
      mem_wb.valid      <= ex_mem.valid;
      mem_wb.regwrite   <= ex_mem.valid & ex_mem.regwrite;
      mem_wb.WA         <= ex_mem.WA;
      mem_wb.data       <= ex_mem.memread ? dc_resp_rdata
                                          : ex_mem.alu_out;
    end else begin
      mem_wb <= '0;
    end
  end

  assign dc_req_addr  = {ex_mem.alu_out[ADDR_W-1:2], 2'b00};
  assign dc_req_wdata = ex_mem.store_data;

  assign EX_MEM_memread  = ex_mem.valid & ex_mem.memread;
  assign EX_MEM_regwrite = ex_mem.valid & ex_mem.regwrite;
  assign EX_MEM_WA       = ex_mem.WA;
  assign EX_MEM_alu_out  = ex_mem.alu_out;

  assign MEM_WB_valid    = mem_wb.valid;
  assign MEM_WB_regwrite = mem_wb.regwrite;
  assign MEM_WB_WA       = mem_wb.WA;
  assign MEM_WB_data     = mem_wb.data;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU, load, store,
// back-to-back ops, reset mid-load and bubbles.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_memread, ex_memwrite, ex_regwrite;
  logic [4:0]  ex_WA;
  logic [31:0] ex_alu_out, ex_store_data;
  logic        dc_req_valid, dc_req_ready, dc_req_we;
  logic [31:0] dc_req_addr, dc_req_wdata;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_rdata;
  logic        mem_stall;
  logic        EX_MEM_memread, EX_MEM_regwrite;
  logic [4:0]  EX_MEM_WA;
  logic [31:0] EX_MEM_alu_out;
  logic        MEM_WB_valid, MEM_WB_regwrite;
  logic [4:0]  MEM_WB_WA;
  logic [31:0] MEM_WB_data;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_memread      (ex_memread),
    .ex_memwrite     (ex_memwrite),
    .ex_regwrite     (ex_regwrite),
    .ex_WA           (ex_WA),
    .ex_alu_out      (ex_alu_out),
    .ex_store_data   (ex_store_data),
    .dc_req_valid    (dc_req_valid),
    .dc_req_ready    (dc_req_ready),
    .dc_req_we       (dc_req_we),
    .dc_req_addr     (dc_req_addr),
    .dc_req_wdata    (dc_req_wdata),
    .dc_resp_valid   (dc_resp_valid),
    .dc_resp_rdata   (dc_resp_rdata),
    .mem_stall       (mem_stall),
    .EX_MEM_memread  (EX_MEM_memread),
    .EX_MEM_regwrite (EX_MEM_regwrite),
    .EX_MEM_WA       (EX_MEM_WA),
    .EX_MEM_alu_out  (EX_MEM_alu_out),
    .MEM_WB_valid    (MEM_WB_valid),
    .MEM_WB_regwrite (MEM_WB_regwrite),
    .MEM_WB_WA       (MEM_WB_WA),
    .MEM_WB_data     (MEM_WB_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $display("FAIL %s: observed %h expected %h",
                  tag, obs, exp);
  endtask

  // Advance one edge; inputs change and checks run 1ns after it.
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ex_none();
    ex_valid      = 1'b0;
    ex_memread    = 1'b0;
    ex_memwrite   = 1'b0;
    ex_regwrite   = 1'b0;
    ex_WA         = 5'd0;
    ex_alu_out    = 32'h0;
    ex_store_data = 32'h0;
  endtask

  task automatic ex_set(input logic rd, input logic wr,
                        input logic rw, input logic [4:0] wa,
                        input logic [31:0] alu,
                        input logic [31:0] sd);
    ex_valid      = 1'b1;
    ex_memread    = rd;
    ex_memwrite   = wr;
    ex_regwrite   = rw;
    ex_WA         = wa;
    ex_alu_out    = alu;
    ex_store_data = sd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    dc_req_ready  = 1'b0;
    dc_resp_valid = 1'b0;
    dc_resp_rdata = 32'h0;
    ex_none();
    cyc(2);
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_req_valid", 32'(dc_req_valid), 0);
    chk("rst_exmem_rw", 32'(EX_MEM_regwrite), 0);
    chk("rst_memwb_valid", 32'(MEM_WB_valid), 0);
    chk("rst_memwb_data", MEM_WB_data, 0);
    chk("rst_req_addr", dc_req_addr, 0);

    // ALU op
    ex_set(0, 0, 1, 5'd8, 32'h1234, 32'h0);
    cyc();
    ex_none();
    #1;
    chk("alu_exmem_rw", 32'(EX_MEM_regwrite), 1);
    chk("alu_exmem_wa", 32'(EX_MEM_WA), 8);
    chk("alu_exmem_out", EX_MEM_alu_out, 32'h1234);
    chk("alu_stall0", 32'(mem_stall), 0);
    cyc();
    chk("alu_wb_valid", 32'(MEM_WB_valid), 1);
    chk("alu_wb_rw", 32'(MEM_WB_regwrite), 1);
    chk("alu_wb_wa", 32'(MEM_WB_WA), 8);
    chk("alu_wb_data", MEM_WB_data, 32'h1234);
    chk("alu_stall1", 32'(mem_stall), 0);

    // LW, accepted at once, response 3 cycles after accept
    ex_set(1, 0, 1, 5'd9, 32'h1003, 32'h0);
    dc_req_ready = 1'b1;
    cyc();
    ex_none();
    #1;
    chk("lw_req_valid", 32'(dc_req_valid), 1);
    chk("lw_req_addr", dc_req_addr, 32'h1000);
    chk("lw_req_we", 32'(dc_req_we), 0);
    chk("lw_fwd_memread", 32'(EX_MEM_memread), 1);
    chk("lw_stall_c1", 32'(mem_stall), 1);
    cyc();
    dc_req_ready = 1'b0;
    #1;
    chk("lw_stall_c2", 32'(mem_stall), 1);
    chk("lw_req_valid_wait", 32'(dc_req_valid), 0);
    chk("lw_wb_bubble_c2", 32'(MEM_WB_valid), 0);
    cyc();
    chk("lw_stall_c3", 32'(mem_stall), 1);
    chk("lw_wb_bubble_c3", 32'(MEM_WB_valid), 0);
    cyc();
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_stall_c4", 32'(mem_stall), 0);
    chk("lw_wb_bubble_c4", 32'(MEM_WB_valid), 0);
    cyc();
    dc_resp_valid = 1'b0;
    dc_resp_rdata = 32'h0;
    #1;
    chk("lw_wb_valid", 32'(MEM_WB_valid), 1);
    chk("lw_wb_rw", 32'(MEM_WB_regwrite), 1);
    chk("lw_wb_wa", 32'(MEM_WB_WA), 9);
    chk("lw_wb_data", MEM_WB_data, 32'hDEADBEEF);
    chk("lw_idle_req", 32'(dc_req_valid), 0);
    cyc();
    chk("lw_wb_once", 32'(MEM_WB_valid), 0);

    // SW with ready held low for 2 cycles
    ex_set(0, 1, 0, 5'd0, 32'h20, 32'h55);
    cyc();
    ex_none();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("sw_req_valid", 32'(dc_req_valid), 1);
      chk("sw_req_we", 32'(dc_req_we), 1);
      chk("sw_req_addr", dc_req_addr, 32'h20);
      chk("sw_req_wdata", dc_req_wdata, 32'h55);
      chk("sw_stall", 32'(mem_stall), 1);
      cyc();
    end
    dc_req_ready = 1'b1;
    #1;
    chk("sw_req_valid_rdy", 32'(dc_req_valid), 1);
    chk("sw_req_addr_rdy", dc_req_addr, 32'h20);
    chk("sw_stall_rdy", 32'(mem_stall), 0);
    cyc();
    dc_req_ready = 1'b0;
    #1;
    chk("sw_wb_valid", 32'(MEM_WB_valid), 1);
    chk("sw_wb_rw", 32'(MEM_WB_regwrite), 0);
    chk("sw_req_done", 32'(dc_req_valid), 0);

    // LW then SW back to back
    ex_set(1, 0, 1, 5'd10, 32'h40, 32'h0);
    dc_req_ready = 1'b1;
    cyc();
    ex_set(0, 1, 0, 5'd0, 32'h80, 32'h77);
    #1;
    chk("b2b_lw_stall", 32'(mem_stall), 1);
    chk("b2b_lw_we", 32'(dc_req_we), 0);
    cyc();
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'hCAFE0001;
    #1;
    chk("b2b_lw_done", 32'(mem_stall), 0);
    cyc();
    ex_none();
    dc_resp_valid = 1'b0;
    dc_resp_rdata = 32'h0;
    #1;
    chk("b2b_sw_req", 32'(dc_req_valid), 1);
    chk("b2b_sw_we", 32'(dc_req_we), 1);
    chk("b2b_sw_addr", dc_req_addr, 32'h80);
    chk("b2b_sw_wdata", dc_req_wdata, 32'h77);
    chk("b2b_lw_wb_wa", 32'(MEM_WB_WA), 10);
    chk("b2b_lw_wb_data", MEM_WB_data, 32'hCAFE0001);
    chk("b2b_sw_stall", 32'(mem_stall), 0);
    cyc();
    dc_req_ready = 1'b0;
    #1;
    chk("b2b_sw_wb_valid", 32'(MEM_WB_valid), 1);
    chk("b2b_sw_wb_rw", 32'(MEM_WB_regwrite), 0);
    chk("b2b_idle", 32'(dc_req_valid), 0);

    // Reset during WAIT, stale response afterwards
    ex_set(1, 0, 1, 5'd11, 32'h100, 32'h0);
    dc_req_ready = 1'b1;
    cyc();
    ex_none();
    cyc();
    dc_req_ready = 1'b0;
    #1;
    chk("rstw_in_wait", 32'(mem_stall), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    dc_resp_valid = 1'b1;
    dc_resp_rdata = 32'h12345678;
    #1;
    chk("rstw_stall", 32'(mem_stall), 0);
    chk("rstw_req_valid", 32'(dc_req_valid), 0);
    chk("rstw_fwd_memread", 32'(EX_MEM_memread), 0);
    chk("rstw_fwd_wa", 32'(EX_MEM_WA), 0);
    chk("rstw_req_addr", dc_req_addr, 0);
    chk("rstw_wb_valid", 32'(MEM_WB_valid), 0);
    chk("rstw_wb_data", MEM_WB_data, 0);
    cyc();
    dc_resp_valid = 1'b0;
    dc_resp_rdata = 32'h0;
    #1;
    chk("rstw_stale_wb", 32'(MEM_WB_valid), 0);
    chk("rstw_stale_stall", 32'(mem_stall), 0);

    // Bubble with regwrite set
    ex_valid    = 1'b0;
    ex_regwrite = 1'b1;
    ex_WA       = 5'd5;
    ex_alu_out  = 32'h99;
    cyc();
    ex_none();
    #1;
    chk("bub_exmem_rw", 32'(EX_MEM_regwrite), 0);
    cyc();
    chk("bub_wb_rw", 32'(MEM_WB_regwrite), 0);
    chk("bub_wb_valid", 32'(MEM_WB_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
